perceptron_trainer: RTL and testbench

- Training-side partner of the bit-serial perceptron classifier. The classifier reads weights; this block produces and writes them.
- Accepts labelled 7-bit feature samples and evaluates them bit-serially against its own weight copy.
- Applies the perceptron learning rule with saturation, and streams every changed weight out on a write port that feeds the classifier's weight array.
- Sits between the sample source and the classifier.

---
 rtl/perceptron_pkg.sv | 23 ++
 rtl/perceptron_trainer_sat_addsub.sv | 30 +++
 rtl/perceptron_trainer.sv | 144 ++++++++++++++
 tb/tb_perceptron_trainer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// Shared constants and types for the perceptron trainer / classifier pair.
// Weights are unsigned Q0.8; the threshold and accumulator are unsigned Q3.8.
package perceptron_pkg;

    localparam int unsigned N_FEAT    = 7;
    localparam int unsigned W_WIDTH   = 8;
    localparam int unsigned ACC_WIDTH = W_WIDTH + 3;
    localparam int unsigned IDX_WIDTH = 3;
    localparam int unsigned CNT_WIDTH = 16;
    localparam int unsigned LR_SHIFT  = 3;
    localparam int unsigned STEP      = 1 << LR_SHIFT;

    localparam logic [W_WIDTH-1:0]   W_INIT  = 8'h80;
    localparam logic [ACC_WIDTH-1:0] TH_INIT = 11'd512;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DECIDE = 2'd2,
        UPDATE = 2'd3
    } state_t;

endpackage

// File: rtl/perceptron_trainer_sat_addsub.sv
// Saturating add/subtract of a constant step.
// Ports: i_val operand, i_sub (1 = subtract, 0 = add), o_val_c result clamped
// to [0, 2^WIDTH-1]. Purely combinational.
module sat_addsub #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned STEP  = 8
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_val_c
);

    localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    // The extra MSB flags carry-out on add and borrow on subtract.
    always_comb begin
        w_sum   = {1'b0, i_val} + STEP_EXT;
        w_diff  = {1'b0, i_val} - STEP_EXT;
        o_val_c = i_val;
        if (i_sub) begin
            o_val_c = w_diff[WIDTH] ? '0 : w_diff[WIDTH-1:0];
        end else begin
            o_val_c = w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/perceptron_trainer.sv
// Perceptron trainer: accepts labelled feature samples, evaluates them
// bit-serially against a local weight copy, applies the saturating perceptron
// learning rule and streams each changed weight out on a write port.
// Ports:
//   clk, rst_n (synchronous, active-high: 1 = reset)
//   sample_valid/sample_ready/sample_x/sample_label/train_en : sample input
//   result_valid/result_pred/result_err                      : prediction pulse
//   wt_wr_en/wt_wr_addr/wt_wr_data                           : weight write port
//   threshold, err_count                                     : status
module perceptron_trainer
    import perceptron_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sample_valid,
    output logic                   sample_ready,
    input  logic [N_FEAT-1:0]      sample_x,
    input  logic                   sample_label,
    input  logic                   train_en,
    output logic                   result_valid,
    output logic                   result_pred,
    output logic                   result_err,
    output logic                   wt_wr_en,
    output logic [IDX_WIDTH-1:0]   wt_wr_addr,
    output logic [W_WIDTH-1:0]     wt_wr_data,
    output logic [ACC_WIDTH-1:0]   threshold,
    output logic [CNT_WIDTH-1:0]   err_count
);

    state_t                 r_state;
    logic [W_WIDTH-1:0]     r_w [N_FEAT];
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [IDX_WIDTH-1:0]   r_idx;
    logic [N_FEAT-1:0]      r_x;
    logic                   r_label;
    logic                   r_train;

    logic [W_WIDTH-1:0]     w_w_cur;
    logic [W_WIDTH-1:0]     w_w_new;
    logic [ACC_WIDTH-1:0]   w_th_new;
    logic                   w_last;
    logic                   w_pred;
    logic                   w_err;

    assign w_w_cur = r_w[r_idx];
    assign w_last  = (r_idx == IDX_WIDTH'(N_FEAT - 1));
    assign w_pred  = (r_acc >= threshold);
    assign w_err   = (w_pred != r_label);

    // Label 1 means the sample was under-scored: raise weights, lower threshold.
    sat_addsub #(.WIDTH(W_WIDTH), .STEP(STEP)) u_wt_step (
        .i_val   (w_w_cur),
        .i_sub   (~r_label),
        .o_val_c (w_w_new)
    );

    sat_addsub #(.WIDTH(ACC_WIDTH), .STEP(STEP)) u_th_step (
        .i_val   (threshold),
        .i_sub   (r_label),
        .o_val_c (w_th_new)
    );

    // Control FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state      <= IDLE;
            r_acc        <= '0;
            r_idx        <= '0;
            r_x          <= '0;
            r_label      <= 1'b0;
            r_train      <= 1'b0;
            sample_ready <= 1'b1;
            result_valid <= 1'b0;
            result_pred  <= 1'b0;
            result_err   <= 1'b0;
            wt_wr_en     <= 1'b0;
            wt_wr_addr   <= '0;
            wt_wr_data   <= '0;
            threshold    <= TH_INIT;
            err_count    <= '0;
            for (int i = 0; i < int'(N_FEAT); i++) begin
                r_w[i] <= W_INIT;
            end
        end else begin
            result_valid <= 1'b0;
            wt_wr_en     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (sample_valid && sample_ready) begin
                        r_x          <= sample_x;
                        r_label      <= sample_label;
                        r_train      <= train_en;
                        r_idx        <= '0;
                        r_acc        <= '0;
                        sample_ready <= 1'b0;
                        r_state      <= ACCUM;
                    end else begin
                        // Ready rises one cycle after returning to IDLE.
                        sample_ready <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (r_x[r_idx]) begin
                        r_acc <= r_acc + ACC_WIDTH'(w_w_cur);
                    end
                    if (w_last) begin
                        r_idx   <= '0;
                        r_state <= DECIDE;
                    end else begin
                        r_idx <= r_idx + IDX_WIDTH'(1);
                    end
                end
                DECIDE: begin
                    result_valid <= 1'b1;
                    result_pred  <= w_pred;
                    result_err   <= w_err;
                    if (w_err && (err_count != '1)) begin
                        err_count <= err_count + CNT_WIDTH'(1);
                    end
                    r_idx   <= '0;
                    r_state <= (w_err && r_train) ? UPDATE : IDLE;
                end
                UPDATE: begin
                    // Saturated weights are still written with their held value.
                    if (r_x[r_idx]) begin
                        r_w[r_idx] <= w_w_new;
                        wt_wr_en   <= 1'b1;
                        wt_wr_addr <= r_idx;
                        wt_wr_data <= w_w_new;
                    end
                    if (w_last) begin
                        threshold <= w_th_new;
                        r_idx     <= '0;
                        r_state   <= IDLE;
                    end else begin
                        r_idx <= r_idx + IDX_WIDTH'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Scoreboard bench for perceptron_trainer: stimulus pushes expected results
// and weight writes into a queue; a negedge monitor pops and compares them.
module tb_perceptron_trainer;
    import perceptron_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 sample_valid = 1'b0;
    logic                 sample_ready;
    logic [N_FEAT-1:0]    sample_x = '0;
    logic                 sample_label = 1'b0;
    logic                 train_en = 1'b0;
    logic                 result_valid;
    logic                 result_pred;
    logic                 result_err;
    logic                 wt_wr_en;
    logic [IDX_WIDTH-1:0] wt_wr_addr;
    logic [W_WIDTH-1:0]   wt_wr_data;
    logic [ACC_WIDTH-1:0] threshold;
    logic [CNT_WIDTH-1:0] err_count;

    always #5 clk = ~clk;

    perceptron_trainer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_x     (sample_x),
        .sample_label (sample_label),
        .train_en     (train_en),
        .result_valid (result_valid),
        .result_pred  (result_pred),
        .result_err   (result_err),
        .wt_wr_en     (wt_wr_en),
        .wt_wr_addr   (wt_wr_addr),
        .wt_wr_data   (wt_wr_data),
        .threshold    (threshold),
        .err_count    (err_count)
    );

    typedef struct {
        bit is_wr;
        bit pred;
        bit err;
        int addr;
        int data;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_vec  = 0;
    int   n_miss = 0;

    // Transaction-level reference state.
    int   mw [N_FEAT];
    int   mth;
    int   mcnt;

    task automatic chk(input string nm, input int act, input int req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic push_res(input bit p, input bit e);
        q.push_back('{is_wr: 1'b0, pred: p, err: e, addr: 0, data: 0});
    endtask

    task automatic push_wr(input int a, input int d);
        q.push_back('{is_wr: 1'b1, pred: 1'b0, err: 1'b0, addr: a, data: d});
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(N_FEAT); i++) mw[i] = 128;
        mth  = 512;
        mcnt = 0;
    endtask

    // Predicts one sample's outputs and returns the cycles until ready returns.
    task automatic model_apply(input int x, input bit lab, input bit tr, output int lat);
        int acc;
        bit pred;
        bit err;
        acc = 0;
        for (int i = 0; i < int'(N_FEAT); i++)
            if (((x >> i) & 1) == 1) acc += mw[i];
        pred = (acc >= mth);
        err  = (pred != lab);
        push_res(pred, err);
        if (err && mcnt < 65535) mcnt++;
        lat = 9;
        if (err && tr) begin
            lat = 16;
            for (int i = 0; i < int'(N_FEAT); i++) begin
                if (((x >> i) & 1) == 1) begin
                    mw[i] = lab ? ((mw[i] + 8 > 255) ? 255 : mw[i] + 8)
                                : ((mw[i] - 8 < 0) ? 0 : mw[i] - 8);
                    push_wr(i, mw[i]);
                end
            end
            mth = lab ? ((mth - 8 < 0) ? 0 : mth - 8)
                      : ((mth + 8 > 2047) ? 2047 : mth + 8);
        end
    endtask

    // Monitor: every DUT output event must match the head of the queue.
    always @(negedge clk) begin
        if (result_valid) begin
            if (q.size() == 0) begin
                chk("result_with_empty_queue", q.size(), 1);
            end else begin
                mon_e = q.pop_front();
                chk("event_kind_result", int'(mon_e.is_wr), 0);
                chk("result_pred", int'(result_pred), int'(mon_e.pred));
                chk("result_err", int'(result_err), int'(mon_e.err));
            end
        end
        if (wt_wr_en) begin
            if (q.size() == 0) begin
                chk("write_with_empty_queue", q.size(), 1);
            end else begin
                mon_e = q.pop_front();
                chk("event_kind_write", int'(mon_e.is_wr), 1);
                chk("wt_wr_addr", int'(wt_wr_addr), mon_e.addr);
                chk("wt_wr_data", int'(wt_wr_data), mon_e.data);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        chk("pending_events_before_reset", q.size(), 0);
        rst_n = 1'b1;
        sample_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        q.delete();
        model_reset();
        chk("rst_sample_ready", int'(sample_ready), 1);
        chk("rst_result_valid", int'(result_valid), 0);
        chk("rst_result_pred", int'(result_pred), 0);
        chk("rst_result_err", int'(result_err), 0);
        chk("rst_wt_wr_en", int'(wt_wr_en), 0);
        chk("rst_wt_wr_addr", int'(wt_wr_addr), 0);
        chk("rst_wt_wr_data", int'(wt_wr_data), 0);
        chk("rst_threshold", int'(threshold), 512);
        chk("rst_err_count", int'(err_count), 0);
    endtask

    // Issues one sample; hold_valid keeps sample_valid high while busy.
    task automatic send(input int x, input bit lab, input bit tr, input bit hold_valid);
        int lat;
        int k;
        k = 0;
        while (!sample_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("ready_before_send", int'(sample_ready), 1);
        model_apply(x, lab, tr, lat);
        sample_x     = N_FEAT'(x);
        sample_label = lab;
        train_en     = tr;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = hold_valid;
        sample_x     = ~N_FEAT'(x);
        chk("ready_drop_after_transfer", int'(sample_ready), 0);
        k = 0;
        while (!sample_ready && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        sample_valid = 1'b0;
        chk("ready_return_latency", k, lat);
        chk("threshold", int'(threshold), mth);
        chk("err_count", int'(err_count), mcnt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        do_reset();

        // Fresh weights: acc 896 >= 512, correct prediction, no update.
        send(32'h7F, 1'b1, 1'b1, 1'b0);
        chk("s1_threshold", int'(threshold), 512);
        // Same features, label 0: error, seven writes of 0x78.
        send(32'h7F, 1'b0, 1'b1, 1'b0);
        chk("s2_threshold", int'(threshold), 520);
        chk("s2_err_count", int'(err_count), 1);

        // From reset: acc 256 < 512, writes only 0 and 2 with 0x88.
        do_reset();
        send(32'h05, 1'b1, 1'b1, 1'b0);
        chk("s3_threshold", int'(threshold), 504);
        // Error with training disabled; valid held while busy must be ignored.
        send(32'h7F, 1'b0, 1'b0, 1'b1);
        chk("s4_threshold", int'(threshold), 504);
        chk("s4_err_count", int'(err_count), 2);

        // Reset during the third weight write.
        do_reset();
        push_res(1'b1, 1'b1);
        push_wr(0, 8'h78);
        push_wr(1, 8'h78);
        push_wr(2, 8'h78);
        sample_x     = 7'h7F;
        sample_label = 1'b0;
        train_en     = 1'b1;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        repeat (11) begin
            @(posedge clk); #1;
        end
        chk("inflight_third_write_en", int'(wt_wr_en), 1);
        chk("inflight_third_write_addr", int'(wt_wr_addr), 2);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        model_reset();
        chk("abort_wt_wr_en", int'(wt_wr_en), 0);
        chk("abort_threshold", int'(threshold), 512);
        chk("abort_err_count", int'(err_count), 0);
        chk("abort_sample_ready", int'(sample_ready), 1);
        chk("abort_queue_drained", q.size(), 0);
        // Weights are back at 0x80: full error update writes 0x78 everywhere.
        send(32'h7F, 1'b0, 1'b1, 1'b0);

        // w0 climbs to 0xFF and is then rewritten unchanged.
        do_reset();
        for (int r = 0; r < 18; r++) send(32'h01, 1'b1, 1'b1, 1'b0);
        chk("wsat_hi_threshold", int'(threshold), 368);
        chk("wsat_hi_err_count", int'(err_count), 18);

        // Walk threshold to 0, then alternate to drain w0 to 0x00 and past it.
        do_reset();
        for (int r = 0; r < 64; r++) send(32'h00, 1'b1, 1'b1, 1'b0);
        chk("th_zero", int'(threshold), 0);
        for (int r = 0; r < 17; r++) begin
            send(32'h01, 1'b0, 1'b1, 1'b0);
            send(32'h00, 1'b1, 1'b1, 1'b0);
        end
        chk("wsat_lo_threshold", int'(threshold), 0);
        chk("wsat_lo_err_count", int'(err_count), 98);
        // At threshold 0 with w0 = 0, acc 0 >= 0 still predicts 1.
        send(32'h01, 1'b0, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("final_queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
